// File: rtl/axis_frame_pkg.sv
// -----------------------------------------------------------------------------
// axis_frame_pkg
// Shared types and helpers for the store-and-forward AXI-Stream frame FIFO.
//   axis_beat_t : stored beat layout {tlast, tid, tdata} at the default widths
//                 (8-bit tid, 8-bit tdata). Instances built with other widths
//                 declare a local struct with the same field order.
//   ptr_level   : occupancy from two wrap-bit pointers of width ptr_w.
// -----------------------------------------------------------------------------
package axis_frame_pkg;

    localparam int unsigned AXIS_TDATA_WIDTH = 8;
    localparam int unsigned AXIS_TID_WIDTH   = 8;

    typedef struct packed {
        logic                        tlast;
        logic [AXIS_TID_WIDTH-1:0]   tid;
        logic [AXIS_TDATA_WIDTH-1:0] tdata;
    } axis_beat_t;

    // Pointers carry one extra wrap bit, so the modular difference is the
    // number of stored entries (0..DEPTH) with no full/empty ambiguity.
    function automatic logic [31:0] ptr_level(input logic [31:0] wr_ptr,
                                              input logic [31:0] rd_ptr,
                                              input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/axis_frame_fifo_ram.sv
// -----------------------------------------------------------------------------
// axis_frame_fifo_ram
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are not reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module axis_frame_fifo_ram
    import axis_frame_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_frame_fifo.sv
// -----------------------------------------------------------------------------
// axis_frame_fifo
// Store-and-forward AXI-Stream frame buffer placed upstream of a switch port.
// A frame is offered downstream only once its tlast beat is stored; tid is
// carried per beat. Output is first-word-fall-through.
//
// Ports:
//   clk, res_n           : clock, asynchronous active-low reset
//   s_axis_*             : producer side (tdata, tid, tvalid, tlast, tready)
//   m_axis_*             : switch side   (tdata, tid, tvalid, tlast, tready)
//   frame_count          : complete frames currently stored
//   level                : beats currently stored
//   drop_count           : dropped oversize frames, saturating (macro only)
//
// Build option: AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
//   undefined : a frame that fills the FIFO without tlast is cut through.
//   defined   : such a frame is discarded and counted on drop_count.
// -----------------------------------------------------------------------------
module axis_frame_fifo
    import axis_frame_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TDATA_WIDTH = 8,
    parameter int unsigned TID_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         res_n,
    input  logic [TDATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [TID_WIDTH-1:0]         s_axis_tid,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [TDATA_WIDTH-1:0]       m_axis_tdata,
    output logic [TID_WIDTH-1:0]         m_axis_tid,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0]   frame_count,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
    ,
    output logic [15:0]                  drop_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = 1 + TID_WIDTH + TDATA_WIDTH;

    // Same field order as axis_beat_t, sized by this instance's parameters.
    typedef struct packed {
        logic                   tlast;
        logic [TID_WIDTH-1:0]   tid;
        logic [TDATA_WIDTH-1:0] tdata;
    } beat_t;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] frame_count_q, frame_count_d;
    logic [CW-1:0] level_w;
    logic          full, empty, oversize;
    logic          push, pop, wr_en;
    beat_t         wr_beat, rd_beat;

    assign level_w  = CW'(ptr_level(32'(wr_ptr_q), 32'(rd_ptr_q), PW));
    assign full     = (level_w == CW'(DEPTH));
    assign empty    = (level_w == '0);
    // Full with no complete frame inside: waiting for tlast would deadlock.
    assign oversize = full && (frame_count_q == '0);

    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
    logic          dropping_q, dropping_d;
    logic [PW-1:0] commit_q, commit_d;
    logic [15:0]   drop_count_q, drop_count_d;

    // While discarding the tail of an oversize frame every beat is accepted.
    assign s_axis_tready = !full || dropping_q;
    assign m_axis_tvalid = !empty && (frame_count_q != '0);
    assign wr_en         = push && !dropping_q;
    assign drop_count    = drop_count_q;
`else
    logic cut_through_q, cut_through_d;

    assign s_axis_tready = !full;
    assign m_axis_tvalid = !empty && ((frame_count_q != '0) || cut_through_q);
    assign wr_en         = push;
`endif

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        frame_count_d = frame_count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en && s_axis_tlast, pop && rd_beat.tlast})
            2'b10:   frame_count_d = frame_count_q + 1'b1;
            2'b01:   frame_count_d = frame_count_q - 1'b1;
            default: frame_count_d = frame_count_q;
        endcase
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
        dropping_d   = dropping_q;
        commit_d     = commit_q;
        drop_count_d = drop_count_q;
        if (wr_en && s_axis_tlast) commit_d = wr_ptr_q + 1'b1;
        if (dropping_q) begin
            if (push && s_axis_tlast) dropping_d = 1'b0;
        end else if (oversize) begin
            // No push is possible here (tready is low), so the rewind is safe.
            wr_ptr_d   = commit_q;
            dropping_d = 1'b1;
            if (drop_count_q != '1) drop_count_d = drop_count_q + 16'd1;
        end
`else
        cut_through_d = cut_through_q;
        if (pop && rd_beat.tlast) cut_through_d = 1'b0;
        else if (oversize)        cut_through_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            frame_count_q <= '0;
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
            dropping_q    <= 1'b0;
            commit_q      <= '0;
            drop_count_q  <= '0;
`else
            cut_through_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            frame_count_q <= frame_count_d;
`ifdef AXIS_FRAME_FIFO_DROP_OVERSIZE_EN
            dropping_q    <= dropping_d;
            commit_q      <= commit_d;
            drop_count_q  <= drop_count_d;
`else
            cut_through_q <= cut_through_d;
`endif
        end
    end

    assign wr_beat = '{tlast: s_axis_tlast, tid: s_axis_tid, tdata: s_axis_tdata};

    axis_frame_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_beat),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_beat)
    );

    assign m_axis_tdata = rd_beat.tdata;
    assign m_axis_tid   = rd_beat.tid;
    assign m_axis_tlast = rd_beat.tlast;
    assign frame_count  = frame_count_q;
    assign level        = level_w;

endmodule
